// File: rtl/memory_bus_pkg.sv
// Shared constants and helpers for the memory bus arbiter slice.
// Configuration macro: MEMBUS_FIXED_PRIO_EN (see rr_arbiter).
package memory_bus_pkg;

    localparam int DEFAULT_N_MASTERS       = 4;
    localparam int DEFAULT_MASTER_ID_WIDTH = 8;
    localparam int DEFAULT_ADDRESS_WIDTH   = 32;
    localparam int DEFAULT_DATA_WIDTH      = 16;

    // Width of a master select index; never below one bit so a select
    // field always exists in the downstream ID.
    function automatic int sel_width(input int n_masters);
        return (n_masters > 1) ? $clog2(n_masters) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Request arbiter for the memory bus arbiter.
// Default build: round-robin, search starts one past the last accepted grant.
// MEMBUS_FIXED_PRIO_EN defined: fixed priority, lowest index wins, no history.
module rr_arbiter
    import memory_bus_pkg::*;
#(
    parameter int N_MASTERS = DEFAULT_N_MASTERS,
    parameter int SEL_WIDTH = sel_width(N_MASTERS)
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic [N_MASTERS-1:0] req,
    input  logic                 advance,
    output logic [SEL_WIDTH-1:0] grant,
    output logic                 grant_valid
);

`ifdef MEMBUS_FIXED_PRIO_EN

    // Lowest requesting index wins; descending scan lets it overwrite others.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        grant       = '0;
        grant_valid = 1'b0;
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant       = SEL_WIDTH'(i);
                grant_valid = 1'b1;
            end
        end
    end

    // Priority is stateless here, so clock, reset and advance have no load.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, clk, rstN, advance};

`else

    logic [SEL_WIDTH-1:0] last_grant;
    int                   idx;

    // Closest requester after last_grant wins; descending offset scan keeps the nearest.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int off = N_MASTERS; off >= 1; off--) begin
            idx = int'(last_grant) + off;
            if (idx >= N_MASTERS) begin
                idx = idx - N_MASTERS;
            end
            if (req[SEL_WIDTH'(idx)]) begin
                grant       = SEL_WIDTH'(idx);
                grant_valid = 1'b1;
            end
        end
    end

    // History moves only when a grant is actually accepted downstream.
    always_ff @(posedge clk or negedge rstN) begin
        // NOTE: clocked state uses non-blocking assignments so all flops update together.
        if (!rstN) begin
            last_grant <= SEL_WIDTH'(N_MASTERS - 1);
        end else if (advance) begin
            last_grant <= grant;
        end
    end

`endif

endmodule

// File: rtl/memory_bus_arbiter.sv
// N-to-1 memory bus arbiter: arbitrated request path into a one-entry
// downstream register, and a one-entry response register routed back to
// the master named in the top bits of the downstream ID.
// Configuration macro: MEMBUS_FIXED_PRIO_EN selects fixed priority.
module memory_bus_arbiter
    import memory_bus_pkg::*;
#(
    parameter  int N_MASTERS       = DEFAULT_N_MASTERS,
    parameter  int MASTER_ID_WIDTH = DEFAULT_MASTER_ID_WIDTH,
    parameter  int ADDRESS_WIDTH   = DEFAULT_ADDRESS_WIDTH,
    parameter  int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
    localparam int SEL_WIDTH       = sel_width(N_MASTERS),
    localparam int DS_ID_WIDTH     = MASTER_ID_WIDTH + SEL_WIDTH
) (
    input  logic                                        clk,
    input  logic                                        rstN,
    // upstream request ports
    input  logic [N_MASTERS-1:0][MASTER_ID_WIDTH-1:0]   upMsID,
    input  logic [N_MASTERS-1:0][ADDRESS_WIDTH-1:0]     upMsAddress,
    input  logic [N_MASTERS-1:0][DATA_WIDTH-1:0]        upMsData,
    input  logic [N_MASTERS-1:0]                        upMsWrite,
    input  logic [N_MASTERS-1:0]                        upMsValid,
    output logic [N_MASTERS-1:0]                        upMsReady,
    // upstream response ports
    output logic [N_MASTERS-1:0][MASTER_ID_WIDTH-1:0]   upSmID,
    output logic [N_MASTERS-1:0][DATA_WIDTH-1:0]        upSmData,
    input  logic [N_MASTERS-1:0]                        upSmReady,
    output logic [N_MASTERS-1:0]                        upSmValid,
    // downstream request port
    output logic [DS_ID_WIDTH-1:0]                      dnMsID,
    output logic [ADDRESS_WIDTH-1:0]                    dnMsAddress,
    output logic [DATA_WIDTH-1:0]                       dnMsData,
    output logic                                        dnMsWrite,
    output logic                                        dnMsValid,
    input  logic                                        dnMsReady,
    // downstream response port
    input  logic [DS_ID_WIDTH-1:0]                      dnSmID,
    input  logic [DATA_WIDTH-1:0]                       dnSmData,
    output logic                                        dnSmReady,
    input  logic                                        dnSmValid
);

    // ---------------- request path ----------------
    logic [SEL_WIDTH-1:0]     grant;
    logic                     grant_valid;
    logic                     req_free;
    logic                     req_accept;
    logic                     req_valid;
    logic [DS_ID_WIDTH-1:0]   req_id;
    logic [ADDRESS_WIDTH-1:0] req_address;
    logic [DATA_WIDTH-1:0]    req_data;
    logic                     req_write;

    rr_arbiter #(
        .N_MASTERS (N_MASTERS),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_arbiter (
        .clk         (clk),
        .rstN        (rstN),
        .req         (upMsValid),
        .advance     (req_accept),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    // The register can take a new entry when empty or draining this cycle.
    // rstN gates acceptance so upMsReady is low for the whole reset window.
    assign req_free   = !req_valid || dnMsReady;
    assign req_accept = rstN && req_free && grant_valid;

    // Only the granted master sees ready, and only when the slot is free.
    always_comb begin
        upMsReady = '0;
        if (req_accept) begin
            upMsReady[grant] = 1'b1;
        end
    end

    // Request valid bit: refilled by the grant whenever the slot is free.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            req_valid <= 1'b0;
        end else if (req_free) begin
            req_valid <= grant_valid;
        end
    end

    // Request payload capture, tagged with the granted master index.
    // NOTE: payload flops carry no reset; the valid bit alone qualifies them.
    always_ff @(posedge clk) begin
        if (req_accept) begin
            req_id      <= {grant, upMsID[grant]};
            req_address <= upMsAddress[grant];
            req_data    <= upMsData[grant];
            req_write   <= upMsWrite[grant];
        end
    end

    assign dnMsValid   = req_valid;
    assign dnMsID      = req_id;
    assign dnMsAddress = req_address;
    assign dnMsData    = req_data;
    assign dnMsWrite   = req_write;

    // ---------------- response path ----------------
    logic [SEL_WIDTH-1:0]       dn_sel;
    logic                       dn_sel_ok;
    logic                       resp_valid;
    logic                       resp_drain;
    logic                       resp_take;
    logic                       resp_load;
    logic [SEL_WIDTH-1:0]       resp_sel;
    logic [MASTER_ID_WIDTH-1:0] resp_id;
    logic [DATA_WIDTH-1:0]      resp_data;

    // Selects beyond the last master are accepted but never stored.
    assign dn_sel     = dnSmID[DS_ID_WIDTH-1 -: SEL_WIDTH];
    assign dn_sel_ok  = 32'(dn_sel) < 32'(N_MASTERS);
    assign resp_drain = |(upSmValid & upSmReady);
    assign dnSmReady  = !resp_valid || resp_drain;
    assign resp_take  = dnSmValid && dnSmReady;
    assign resp_load  = resp_take && dn_sel_ok;

    // Route the held response to the one master it belongs to.
    always_comb begin
        upSmValid = '0;
        if (resp_valid) begin
            upSmValid[resp_sel] = 1'b1;
        end
    end

    assign upSmID   = {N_MASTERS{resp_id}};
    assign upSmData = {N_MASTERS{resp_data}};

    // Response valid bit: a load wins over a simultaneous drain.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            resp_valid <= 1'b0;
        end else if (resp_load) begin
            resp_valid <= 1'b1;
        end else if (resp_drain) begin
            resp_valid <= 1'b0;
        end
    end

    // Response payload capture: split the downstream ID into select and master ID.
    always_ff @(posedge clk) begin
        if (resp_load) begin
            resp_sel  <= dn_sel;
            resp_id   <= dnSmID[MASTER_ID_WIDTH-1:0];
            resp_data <= dnSmData;
        end
    end

endmodule

// File: doc/memory_bus_arbiter.md
MEMORY_BUS_ARBITER -- requirements
Module: memory_bus_arbiter

Interface
REQ-001 Parameter N_MASTERS, default 4: number of upstream master ports, range 2..16.
REQ-002 Parameter MASTER_ID_WIDTH, default 8: upstream per-master ID width.
REQ-003 Parameter ADDRESS_WIDTH, default 32, and DATA_WIDTH, default 16: address and data widths, identical on all ports.
REQ-004 Derived SEL_WIDTH = $clog2(N_MASTERS); downstream ID width DS_ID_WIDTH = MASTER_ID_WIDTH + SEL_WIDTH.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rstN  input  1  asynchronous, active-low reset.
REQ-007 up*  per-master packed arrays [N_MASTERS]: msID, msAddress, msData, msWrite and msValid are inputs; msReady is an output; smID and smData are outputs; smReady is an input; smValid is an output.
REQ-008 dn*  single downstream port: msID[DS_ID_WIDTH], msAddress, msData, msWrite and msValid are outputs; msReady is an input; smID[DS_ID_WIDTH] and smData are inputs; smReady is an output; smValid is an input.

Function
REQ-009 Request path: one-entry output register feeds dnMs*; dnMsValid is driven directly from the register valid bit.
REQ-010 Register "free" = !valid || dnMsReady; a new request is accepted only when free.
REQ-011 When free, grant exactly one requesting master per cycle (upMsValid high); upMsReady[g] = free && grant==g; all other upMsReady = 0.
REQ-012 Arbitration is round-robin: search starts at lastGrant+1 modulo N_MASTERS; lastGrant updates only on an accepted transfer.
REQ-013 Captured dnMsID = {g[SEL_WIDTH-1:0], upMsID[g]}; address, data and write are copied unchanged.
REQ-014 Request latency is 1 cycle from upstream handshake to dnMsValid; sustained throughput is 1 request/cycle while dnMsReady stays high.
REQ-015 dnMs* fields hold stable while dnMsValid && !dnMsReady.
REQ-016 Response path: one-entry response register; dnSmReady = !respValid || upSmReady[respSel].
REQ-017 On dnSmValid && dnSmReady: capture respSel = dnSmID[DS_ID_WIDTH-1 -: SEL_WIDTH], the low MASTER_ID_WIDTH ID bits and the data.
REQ-018 upSmValid[i] = respValid && respSel==i; upSmID and upSmData broadcast to all ports from the register.
REQ-019 A dnSmID select value >= N_MASTERS is consumed and dropped; the response register is not loaded.
REQ-020 Simultaneous drain and load of either register in one cycle is lossless: the old entry leaves and the new entry is stored.
REQ-021 Request and response paths are independent; neither stalls the other.

Reset
REQ-022 While rstN is low: both valid bits 0, lastGrant = N_MASTERS-1, all upMsReady 0, dnMsValid 0, upSmValid 0.
REQ-023 Datapath registers are not reset; an in-flight request or response at reset assertion is discarded.
REQ-024 dnSmReady is 1 in the first cycle after reset release.

Configuration
REQ-025 Macro MEMBUS_FIXED_PRIO_EN defined: fixed priority, lowest index wins; lastGrant is removed.
REQ-026 Macro MEMBUS_FIXED_PRIO_EN undefined: round-robin per REQ-012.

Structure
REQ-027 Package memory_bus_pkg holds default width constants and an sel_width function/localparam helper.
REQ-028 Sub-module rr_arbiter (request vector, advance, grant index, grant-valid), holding lastGrant; it is instantiated once.

Verification
REQ-029 N=4, masters 0-3 all continuously valid, dnMsReady=1: grants 0,1,2,3,0 on consecutive cycles, and dnMsID[9:8] matches each grant.
REQ-030 Master 2 issues ID 0x5A with dnMsReady=0 for 3 cycles: dnMs* is stable at {2'd2,8'h5A}, upMsReady is all 0, and the transfer completes on the 4th cycle.
REQ-031 dnSmID=10'h2A7 with upSmReady[2]=0: upSmValid=4'b0100, upSmID=8'hA7, dnSmReady=0 until upSmReady[2]=1.
REQ-032 N=3, dnSmID select=3: the response is accepted by dnSmReady=1 and no upSmValid is asserted.
REQ-033 rstN pulsed low mid-burst: outputs go to REQ-022 values asynchronously, and after release the first grant goes to master 0.
REQ-034 MEMBUS_FIXED_PRIO_EN defined, masters 1 and 3 continuously valid: master 1 is granted every cycle.
